// File: rtl/rca_repair_pkg.sv
// ---------------------------------------------------------------------------
// rca_repair_pkg
// Shared types and helpers for the ripple-carry adder repair controller.
//   state_t   : controller state encoding
//   popcount  : number of set bits in a (zero-extended) fault vector
//   prio_idx  : index of the lowest set bit of a fault vector (0 if none)
// Vectors are passed zero-extended to MAX_SLICE bits so one function serves
// every N_SLICE parameterisation up to MAX_SLICE slices.
// ---------------------------------------------------------------------------
package rca_repair_pkg;

   localparam int MAX_SLICE = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TEST,
      ST_EVAL,
      ST_REPAIRED,
      ST_FAIL
   } state_t;

   function automatic int popcount(input logic [MAX_SLICE-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < MAX_SLICE; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

   // Lowest set bit wins; with a single confirmed slice it is simply that slice.
   function automatic int prio_idx(input logic [MAX_SLICE-1:0] v);
      int idx;
      idx = 0;
      for (int i = MAX_SLICE - 1; i >= 0; i--) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rca_repair_ctrl_fault_conf_cnt.sv
// ---------------------------------------------------------------------------
// fault_conf_cnt
// Saturating mismatch-confirmation counter for one adder slice.
//   clk       : clock
//   init_n    : asynchronous active-low reset
//   clr       : synchronous clear (wins over inc)
//   inc       : add one hit this cycle (ignored once saturated)
//   confirmed : registered flag, high while the count equals CONF_CNT
// ---------------------------------------------------------------------------
module fault_conf_cnt #(
   parameter int CONF_CNT = 2
) (
   input  logic clk,
   input  logic init_n,
   input  logic clr,
   input  logic inc,
   output logic confirmed
);

   localparam int              CNT_W = $clog2(CONF_CNT + 1);
   localparam logic [CNT_W-1:0] SAT  = CNT_W'(CONF_CNT);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // NOTE: every always_comb output gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      cnt_nxt = cnt;
      if (clr) begin
         cnt_nxt = '0;
      end else if (inc && (cnt != SAT)) begin
         cnt_nxt = cnt + 1'b1;
      end
   end

   // The flag is derived from the next count so it stays a plain register
   // output yet changes on the same edge as the count itself.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         cnt       <= '0;
         confirmed <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         confirmed <= (cnt_nxt == SAT);
      end
   end

endmodule

// File: rtl/rca_repair_ctrl.sv
// ---------------------------------------------------------------------------
// rca_repair_ctrl
// Fault-confirmation and reconfiguration controller for a ripple-carry adder
// with one spare slice. Runs a TEST_CYCLES self-test window, accumulates
// per-slice comparator mismatches in sticky saturating counters, and on
// completion steers the datapath around a single confirmed faulty slice.
// Two or more confirmed slices are reported as an uncorrectable failure.
//
// Ports:
//   clk        : clock, all state on rising edge
//   init_n     : asynchronous active-low reset
//   start      : begin a test run (IDLE only)
//   clr        : clear counters and selects (IDLE and FAIL only)
//   comp_valid : comp is meaningful this cycle
//   comp       : mismatch bits, bit g*N_SLICE+s = group g of slice s
//   test_en    : datapath in test mode
//   busy       : controller not idle
//   done       : one-cycle pulse, run finished with a repairable result
//   fail       : sticky, two or more slices confirmed faulty
//   fault_vec  : confirmed-faulty slices
//   fault_idx  : index of the confirmed faulty slice (0 if none)
//   is         : input-shift select
//   cs         : carry/output select, one-hot (all zero while testing)
//   ss         : sum-shift select
// ---------------------------------------------------------------------------
import rca_repair_pkg::*;

module rca_repair_ctrl #(
   parameter int N_SLICE     = 4,
   parameter int N_GRP       = 2,
   parameter int CONF_CNT    = 2,
   parameter int TEST_CYCLES = 16,
   localparam int IDX_W      = ($clog2(N_SLICE) < 1) ? 1 : $clog2(N_SLICE)
) (
   input  logic                     clk,
   input  logic                     init_n,
   input  logic                     start,
   input  logic                     clr,
   input  logic                     comp_valid,
   input  logic [N_SLICE*N_GRP-1:0] comp,
   output logic                     test_en,
   output logic                     busy,
   output logic                     done,
   output logic                     fail,
   output logic [N_SLICE-1:0]       fault_vec,
   output logic [IDX_W-1:0]         fault_idx,
   output logic [N_SLICE-2:0]       is,
   output logic [N_SLICE:0]         cs,
   output logic [N_SLICE-1:0]       ss
);

   localparam int                CYC_W  = ($clog2(TEST_CYCLES) < 1) ? 1 : $clog2(TEST_CYCLES);
   localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(TEST_CYCLES - 1);
   // No faulty slice: the spare position (bit N_SLICE) carries the output.
   localparam logic [N_SLICE:0]  CS_RST = {1'b1, {N_SLICE{1'b0}}};

   state_t               state;
   logic [CYC_W-1:0]     cyc_cnt;
   logic [N_SLICE:0]     cs_q;
   logic [N_SLICE-1:0]   slice_hit;
   logic                 cnt_clr;

   logic [MAX_SLICE-1:0] fv_ext;
   int                   n_fault;
   int                   f_idx;
   logic [N_SLICE-2:0]   is_nxt;
   logic [N_SLICE-1:0]   ss_nxt;
   logic [N_SLICE:0]     cs_nxt;
   logic [IDX_W-1:0]     idx_nxt;

   // A slice is hit when any of its comparator groups reports a mismatch.
   always_comb begin
      slice_hit = '0;
      for (int s = 0; s < N_SLICE; s++) begin
         for (int g = 0; g < N_GRP; g++) begin
            if (comp[g*N_SLICE + s]) slice_hit[s] = 1'b1;
         end
      end
   end

   // clr is only honoured where the FSM accepts it; elsewhere it is dropped.
   assign cnt_clr = clr && ((state == ST_IDLE) || (state == ST_FAIL));

   for (genvar s = 0; s < N_SLICE; s++) begin : g_conf
      fault_conf_cnt #(
         .CONF_CNT (CONF_CNT)
      ) u_cnt (
         .clk       (clk),
         .init_n    (init_n),
         .clr       (cnt_clr),
         .inc       ((state == ST_TEST) && comp_valid && slice_hit[s]),
         .confirmed (fault_vec[s])
      );
   end

   // Select vectors the EVAL edge would load, derived from the fault vector.
   always_comb begin
      fv_ext                = '0;
      fv_ext[N_SLICE-1:0]   = fault_vec;
      n_fault               = popcount(fv_ext);
      f_idx                 = prio_idx(fv_ext);
      is_nxt                = '0;
      ss_nxt                = '0;
      cs_nxt                = CS_RST;
      idx_nxt               = '0;
      if (n_fault != 0) begin
         for (int k = 0; k < N_SLICE - 1; k++) is_nxt[k] = (k >= f_idx);
         for (int k = 0; k < N_SLICE; k++)     ss_nxt[k] = (k >= f_idx);
         for (int k = 0; k <= N_SLICE; k++)    cs_nxt[k] = (k == f_idx);
         idx_nxt = IDX_W'(f_idx);
      end
   end

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state     <= ST_IDLE;
         cyc_cnt   <= '0;
         test_en   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fail      <= 1'b0;
         fault_idx <= '0;
         is        <= '0;
         ss        <= '0;
         cs_q      <= CS_RST;
      end else begin
         case (state)
            ST_IDLE: begin
               if (clr) begin
                  fault_idx <= '0;
                  is        <= '0;
                  ss        <= '0;
                  cs_q      <= CS_RST;
               end else if (start) begin
                  state   <= ST_TEST;
                  cyc_cnt <= '0;
                  test_en <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            ST_TEST: begin
               if (cyc_cnt == CYC_LAST) begin
                  state   <= ST_EVAL;
                  test_en <= 1'b0;
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
            ST_EVAL: begin
               if (n_fault <= 1) begin
                  state     <= ST_REPAIRED;
                  done      <= 1'b1;
                  fault_idx <= idx_nxt;
                  is        <= is_nxt;
                  ss        <= ss_nxt;
                  cs_q      <= cs_nxt;
               end else begin
                  // Uncorrectable: selects keep whatever the last good run chose.
                  state <= ST_FAIL;
                  fail  <= 1'b1;
               end
            end
            ST_REPAIRED: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            ST_FAIL: begin
               if (clr) begin
                  state     <= ST_IDLE;
                  fail      <= 1'b0;
                  busy      <= 1'b0;
                  fault_idx <= '0;
                  is        <= '0;
                  ss        <= '0;
                  cs_q      <= CS_RST;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The datapath must not select any slice output while under test.
   assign cs = cs_q & {(N_SLICE + 1){~test_en}};

endmodule

// File: tb/tb_rca_repair_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rca_repair_ctrl
// Directed self-checking bench for rca_repair_ctrl: a default 4-slice
// instance and an 8-slice, 3-group, single-cycle-window instance.
// ---------------------------------------------------------------------------
module tb_rca_repair_ctrl;

   logic clk = 1'b0;
   logic init_n = 1'b0;

   // Default instance
   logic       start = 1'b0, clr = 1'b0, comp_valid = 1'b0;
   logic [7:0] comp = '0;
   logic       test_en, busy, done, fail;
   logic [3:0] fault_vec, ss;
   logic [1:0] fault_idx;
   logic [2:0] is_v;
   logic [4:0] cs;

   // Wide instance: N_SLICE=8, N_GRP=3, CONF_CNT=1, TEST_CYCLES=1
   logic        start2 = 1'b0, clr2 = 1'b0, comp_valid2 = 1'b0;
   logic [23:0] comp2 = '0;
   logic        test_en2, busy2, done2, fail2;
   logic [7:0]  fault_vec2, ss2;
   logic [2:0]  fault_idx2;
   logic [6:0]  is2;
   logic [8:0]  cs2;

   int checks = 0;
   int errors = 0;

   rca_repair_ctrl #(.N_SLICE(4), .N_GRP(2), .CONF_CNT(2), .TEST_CYCLES(16)) dut (
      .clk(clk), .init_n(init_n), .start(start), .clr(clr),
      .comp_valid(comp_valid), .comp(comp),
      .test_en(test_en), .busy(busy), .done(done), .fail(fail),
      .fault_vec(fault_vec), .fault_idx(fault_idx),
      .is(is_v), .cs(cs), .ss(ss)
   );

   rca_repair_ctrl #(.N_SLICE(8), .N_GRP(3), .CONF_CNT(1), .TEST_CYCLES(1)) dut2 (
      .clk(clk), .init_n(init_n), .start(start2), .clr(clr2),
      .comp_valid(comp_valid2), .comp(comp2),
      .test_en(test_en2), .busy(busy2), .done(done2), .fail(fail2),
      .fault_vec(fault_vec2), .fault_idx(fault_idx2),
      .is(is2), .cs(cs2), .ss(ss2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One run on the default instance: start, drive c with comp_valid for the
   // first nvalid window cycles, stop at done/fail (bounded at 40 cycles).
   task automatic run(input logic [7:0] c, input int nvalid,
                      output int lat, output int te_cnt, output bit cs_bad);
      int idx;
      idx = 0; te_cnt = 0; cs_bad = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      while (lat < 40 && !done && !fail) begin
         if (test_en) begin
            te_cnt++;
            if (cs !== 5'b0) cs_bad = 1'b1;
            comp       = c;
            comp_valid = (idx < nvalid);
            idx++;
         end else begin
            comp       = '0;
            comp_valid = 1'b0;
         end
         tick();
         lat++;
      end
      comp       = '0;
      comp_valid = 1'b0;
   endtask

   initial begin
      int  lat, te;
      bit  csb;
      bit  done_seen;

      // ---- reset state
      repeat (2) tick();
      check("rst_test_en",  32'(test_en),   32'h0);
      check("rst_busy",     32'(busy),      32'h0);
      check("rst_done",     32'(done),      32'h0);
      check("rst_fail",     32'(fail),      32'h0);
      check("rst_fvec",     32'(fault_vec), 32'h0);
      check("rst_idx",      32'(fault_idx), 32'h0);
      check("rst_is",       32'(is_v),      32'h0);
      check("rst_ss",       32'(ss),        32'h0);
      check("rst_cs",       32'(cs),        32'h10);
      check("rst_cs2",      32'(cs2),       32'h100);
      init_n = 1'b1;
      tick();

      // ---- run 1: no mismatches
      run(8'h00, 0, lat, te, csb);
      check("r1_latency",   32'(lat),  32'd18);
      check("r1_test_len",  32'(te),   32'd16);
      check("r1_cs_forced", 32'(csb),  32'h0);
      check("r1_done",      32'(done), 32'h1);
      check("r1_cs",        32'(cs),   32'h10);
      check("r1_is",        32'(is_v), 32'h0);
      check("r1_ss",        32'(ss),   32'h0);
      check("r1_fail",      32'(fail), 32'h0);
      tick();
      check("r1_done_pulse", 32'(done), 32'h0);
      check("r1_idle",       32'(busy), 32'h0);

      // ---- run 2: slice 2 hit twice
      run(8'h04, 2, lat, te, csb);
      check("r2_latency", 32'(lat),       32'd18);
      check("r2_done",    32'(done),      32'h1);
      check("r2_fvec",    32'(fault_vec), 32'h4);
      check("r2_idx",     32'(fault_idx), 32'h2);
      check("r2_cs",      32'(cs),        32'h04);
      check("r2_is",      32'(is_v),      32'h4);
      check("r2_ss",      32'(ss),        32'hC);
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_cs",   32'(cs),        32'h10);
      check("clr_fvec", 32'(fault_vec), 32'h0);
      check("clr_idx",  32'(fault_idx), 32'h0);

      // ---- runs 3/4: one hit per run on slice 1 group 1, sticky counters
      run(8'h20, 1, lat, te, csb);
      check("r3_done", 32'(done),      32'h1);
      check("r3_fvec", 32'(fault_vec), 32'h0);
      check("r3_cs",   32'(cs),        32'h10);
      tick();
      run(8'h20, 1, lat, te, csb);
      check("r4_done", 32'(done),      32'h1);
      check("r4_cs",   32'(cs),        32'h02);
      check("r4_idx",  32'(fault_idx), 32'h1);
      check("r4_is",   32'(is_v),      32'h6);
      check("r4_ss",   32'(ss),        32'hE);
      tick();

      // ---- run 5: slices 0 and 3 confirmed as well -> FAIL, selects held
      run(8'h09, 2, lat, te, csb);
      check("r5_latency", 32'(lat),       32'd18);
      check("r5_fail",    32'(fail),      32'h1);
      check("r5_done",    32'(done),      32'h0);
      check("r5_fvec",    32'(fault_vec), 32'hB);
      check("r5_cs_keep", 32'(cs),        32'h02);
      check("r5_is_keep", 32'(is_v),      32'h6);
      check("r5_ss_keep", 32'(ss),        32'hE);
      check("r5_idx_keep",32'(fault_idx), 32'h1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("fail_start_ign_te",   32'(test_en), 32'h0);
      check("fail_start_ign_fail", 32'(fail),    32'h1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("fail_clr_fail", 32'(fail),      32'h0);
      check("fail_clr_busy", 32'(busy),      32'h0);
      check("fail_clr_cs",   32'(cs),        32'h10);
      check("fail_clr_fvec", 32'(fault_vec), 32'h0);

      // ---- start and clr together in IDLE: clr wins, start dropped
      start = 1'b1;
      clr   = 1'b1;
      tick();
      start = 1'b0;
      clr   = 1'b0;
      check("start_clr_busy", 32'(busy),    32'h0);
      check("start_clr_te",   32'(test_en), 32'h0);

      // ---- mid-TEST: clr ignored, then async reset
      start = 1'b1;
      tick();
      start = 1'b0;
      comp = 8'h01;
      comp_valid = 1'b1;
      repeat (2) tick();
      comp = '0;
      comp_valid = 1'b0;
      tick();
      check("mid_fvec", 32'(fault_vec), 32'h1);
      check("mid_cs",   32'(cs),        32'h0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("mid_clr_ign_fvec", 32'(fault_vec), 32'h1);
      check("mid_clr_ign_te",   32'(test_en),   32'h1);
      init_n = 1'b0;
      #1;
      check("arst_te",   32'(test_en),   32'h0);
      check("arst_busy", 32'(busy),      32'h0);
      check("arst_fvec", 32'(fault_vec), 32'h0);
      check("arst_cs",   32'(cs),        32'h10);
      check("arst_idx",  32'(fault_idx), 32'h0);
      repeat (2) tick();
      init_n = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) done_seen = 1'b1;
      end
      check("arst_no_done", 32'(done_seen), 32'h0);
      check("arst_idle",    32'(busy),      32'h0);

      // ---- wide instance: slice 7 group 2 (bit 23) in a 1-cycle window
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      check("w_test_en", 32'(test_en2), 32'h1);
      comp2 = 24'h800000;
      comp_valid2 = 1'b1;
      tick();
      comp2 = '0;
      comp_valid2 = 1'b0;
      check("w_test_end", 32'(test_en2), 32'h0);
      tick();
      check("w_done", 32'(done2),      32'h1);
      check("w_fvec", 32'(fault_vec2), 32'h80);
      check("w_idx",  32'(fault_idx2), 32'h7);
      check("w_cs",   32'(cs2),        32'h080);
      check("w_is",   32'(is2),        32'h00);
      check("w_ss",   32'(ss2),        32'h80);
      check("w_fail", 32'(fail2),      32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
